// File: rtl/aib_link_bringup_seq_if.sv
// aib_link_bringup_seq_if
//   AVMM configuration port between the link bring-up sequencer and the
//   bridge master's AIB AVMM slave.
//   cfg_avmm_addr     17-bit register address
//   cfg_avmm_byte_en  byte enables, all ones while writing
//   cfg_avmm_write    write strobe
//   cfg_avmm_wdata    write data
//   cfg_avmm_waitreq  slave stall; the master holds its request while high
interface aib_link_bringup_seq_if #(
   parameter int AVMM_WIDTH = 32,
   parameter int BYTE_WIDTH = 4
);
   logic [16:0]           cfg_avmm_addr;
   logic [BYTE_WIDTH-1:0] cfg_avmm_byte_en;
   logic                  cfg_avmm_write;
   logic [AVMM_WIDTH-1:0] cfg_avmm_wdata;
   logic                  cfg_avmm_waitreq;

   modport master (
      output cfg_avmm_addr, cfg_avmm_byte_en, cfg_avmm_write, cfg_avmm_wdata,
      input  cfg_avmm_waitreq
   );

   modport slave (
      input  cfg_avmm_addr, cfg_avmm_byte_en, cfg_avmm_write, cfg_avmm_wdata,
      output cfg_avmm_waitreq
   );
endinterface

// File: rtl/aib_link_bringup_seq.sv
// aib_link_bringup_seq
//   Leader-side AIB link bring-up sequencer. Writes a config table over AVMM,
//   releases adapter reset, raises DCC/DLL lock requests and ns_mac_rdy, then
//   waits for far-side MAC ready plus RX alignment to hold for STABLE_CYC
//   cycles. Timeouts and link drops retry after a backoff, up to MAX_RETRY.
// Ports
//   i_cfg_avmm_clk / i_cfg_avmm_rst   clock, synchronous active-high reset
//   start                             level: 1 = bring up, 0 = abort to IDLE
//   cfg_tbl_addr / cfg_tbl_data       packed config table, entry i at slot i
//   avmm                              AVMM master port (interface)
//   ns_adapter_rstn, ms_*_lock_req,
//   ns_mac_rdy                        per-channel outputs (active bits only)
//   fs_mac_rdy, m_rx_align_done       per-channel status (active bits only)
//   link_up, link_fail, retry_cnt,
//   seq_state                         status / debug, all registered
module aib_link_bringup_seq #(
   parameter int NBR_CHNLS    = 24,
   parameter int ACTIVE_CHNLS = 1,
   parameter int AVMM_WIDTH   = 32,
   parameter int BYTE_WIDTH   = 4,
   parameter int NUM_CFG      = 4,
   parameter int RST_DLY      = 64,
   parameter int STABLE_CYC   = 16,
   parameter int TIMEOUT      = 65535,
   parameter int BACKOFF_CYC  = 256,
   parameter int MAX_RETRY    = 3
) (
   input  logic                                            i_cfg_avmm_clk,
   input  logic                                            i_cfg_avmm_rst,
   input  logic                                            start,
   input  logic [((NUM_CFG > 0) ? NUM_CFG : 1)*17-1:0]         cfg_tbl_addr,
   input  logic [((NUM_CFG > 0) ? NUM_CFG : 1)*AVMM_WIDTH-1:0] cfg_tbl_data,
   aib_link_bringup_seq_if.master                          avmm,
   output logic [NBR_CHNLS-1:0]                            ns_adapter_rstn,
   output logic [NBR_CHNLS-1:0]                            ms_rx_dcc_dll_lock_req,
   output logic [NBR_CHNLS-1:0]                            ms_tx_dcc_dll_lock_req,
   output logic [NBR_CHNLS-1:0]                            ns_mac_rdy,
   input  logic [NBR_CHNLS-1:0]                            fs_mac_rdy,
   input  logic [NBR_CHNLS-1:0]                            m_rx_align_done,
   output logic                                            link_up,
   output logic                                            link_fail,
   output logic [3:0]                                      retry_cnt,
   output logic [3:0]                                      seq_state
);

   // A zero-entry table still needs one legal slot for the port width.
   localparam int TBL_N = (NUM_CFG > 0) ? NUM_CFG : 1;
   localparam int IW    = (TBL_N > 1) ? $clog2(TBL_N) : 1;
   localparam int TMAX  = (RST_DLY > TIMEOUT) ?
                          ((RST_DLY > BACKOFF_CYC) ? RST_DLY : BACKOFF_CYC) :
                          ((TIMEOUT > BACKOFF_CYC) ? TIMEOUT : BACKOFF_CYC);
   localparam int TW    = $clog2(TMAX + 1);
   localparam int SW    = $clog2(STABLE_CYC + 1);

   // Terminal values: each counter stops at its compare value, so none wraps.
   localparam logic [IW-1:0] IDX_LAST = IW'(TBL_N - 1);
   localparam logic [TW-1:0] RST_LAST = TW'(RST_DLY - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] BO_LAST  = TW'(BACKOFF_CYC - 1);
   localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYC - 1);

   function automatic logic [NBR_CHNLS-1:0] act_mask_f();
      logic [NBR_CHNLS-1:0] m;
      for (int i = 0; i < NBR_CHNLS; i++) m[i] = (i < ACTIVE_CHNLS);
      return m;
   endfunction
   localparam logic [NBR_CHNLS-1:0] ACT_MASK = act_mask_f();

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CFG_WR    = 4'd1,
      S_ADAPT_RST = 4'd2,
      S_LOCK_REQ  = 4'd3,
      S_WAIT_ALGN = 4'd4,
      S_LINK_UP   = 4'd5,
      S_BACKOFF   = 4'd6,
      S_FAIL      = 4'd7
   } state_t;

   state_t         state_q, nxt_state;
   logic [IW-1:0]  idx_q,   nxt_idx;
   logic [TW-1:0]  tmr_q,   nxt_tmr;
   logic [SW-1:0]  stb_q,   nxt_stb;
   logic [3:0]     retry_q, nxt_retry;
   logic           ok;
   logic           wr_n, rstn_n, lock_n;

   // Inactive channels are forced to 1 so they never block the AND-reduce.
   assign ok = &((fs_mac_rdy | ~ACT_MASK) & (m_rx_align_done | ~ACT_MASK));

   always_comb begin
      nxt_state = state_q;
      nxt_idx   = idx_q;
      nxt_tmr   = tmr_q;
      nxt_stb   = stb_q;
      nxt_retry = retry_q;
      case (state_q)
         S_IDLE: begin
            nxt_idx = '0;
            nxt_tmr = '0;
            nxt_stb = '0;
            if (start) nxt_state = (NUM_CFG == 0) ? S_ADAPT_RST : S_CFG_WR;
         end
         S_CFG_WR: begin
            // The write is always pending here, so an abort waits for accept.
            if (!avmm.cfg_avmm_waitreq) begin
               if (!start)                 nxt_state = S_IDLE;
               else if (idx_q == IDX_LAST) begin
                  nxt_state = S_ADAPT_RST;
                  nxt_tmr   = '0;
               end else                    nxt_idx = idx_q + 1'b1;
            end
         end
         S_ADAPT_RST: begin
            if (!start)                 nxt_state = S_IDLE;
            else if (tmr_q == RST_LAST) begin
               nxt_state = S_LOCK_REQ;
               nxt_tmr   = '0;
            end else                    nxt_tmr = tmr_q + 1'b1;
         end
         S_LOCK_REQ: begin
            nxt_tmr = '0;
            nxt_stb = '0;
            nxt_state = start ? S_WAIT_ALGN : S_IDLE;
         end
         S_WAIT_ALGN: begin
            nxt_stb = ok ? stb_q + 1'b1 : '0;
            nxt_tmr = tmr_q + 1'b1;
            if (!start) nxt_state = S_IDLE;
            else if (ok && stb_q == STB_LAST) begin
               // Stability wins over a timeout landing on the same cycle.
               nxt_state = S_LINK_UP;
               nxt_stb   = stb_q;
               nxt_tmr   = '0;
            end else if (tmr_q == TO_LAST) begin
               nxt_state = S_BACKOFF;
               nxt_retry = retry_q + 1'b1;
               nxt_tmr   = '0;
            end
         end
         S_LINK_UP: begin
            if (!start) nxt_state = S_IDLE;
            else if (!ok) begin
               nxt_state = S_BACKOFF;
               nxt_retry = retry_q + 1'b1;
               nxt_tmr   = '0;
            end
         end
         S_BACKOFF: begin
            // retry_cnt was bumped on entry; only MAX_RETRY+1 reaches FAIL.
            if (!start)                           nxt_state = S_IDLE;
            else if (retry_q > 4'(MAX_RETRY))     nxt_state = S_FAIL;
            else if (tmr_q == BO_LAST) begin
               nxt_state = S_ADAPT_RST;
               nxt_tmr   = '0;
            end else                              nxt_tmr = tmr_q + 1'b1;
         end
         S_FAIL: begin
            if (!start) nxt_state = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase
      // Clear on the way into IDLE so IDLE itself already shows zero.
      if (nxt_state == S_IDLE) nxt_retry = '0;
   end

   // Output decode from next state so every output is a flop.
   always_comb begin
      wr_n   = (nxt_state == S_CFG_WR);
      lock_n = (nxt_state == S_LOCK_REQ) || (nxt_state == S_WAIT_ALGN) ||
               (nxt_state == S_LINK_UP);
      rstn_n = lock_n || (nxt_state == S_ADAPT_RST);
   end

   always_ff @(posedge i_cfg_avmm_clk) begin
      if (i_cfg_avmm_rst) begin
         state_q                <= S_IDLE;
         idx_q                  <= '0;
         tmr_q                  <= '0;
         stb_q                  <= '0;
         retry_q                <= '0;
         avmm.cfg_avmm_write    <= 1'b0;
         avmm.cfg_avmm_addr     <= '0;
         avmm.cfg_avmm_wdata    <= '0;
         avmm.cfg_avmm_byte_en  <= '0;
         ns_adapter_rstn        <= '0;
         ms_rx_dcc_dll_lock_req <= '0;
         ms_tx_dcc_dll_lock_req <= '0;
         ns_mac_rdy             <= '0;
         link_up                <= 1'b0;
         link_fail              <= 1'b0;
      end else begin
         state_q                <= nxt_state;
         idx_q                  <= nxt_idx;
         tmr_q                  <= nxt_tmr;
         stb_q                  <= nxt_stb;
         retry_q                <= nxt_retry;
         avmm.cfg_avmm_write    <= wr_n;
         avmm.cfg_avmm_addr     <= wr_n ? cfg_tbl_addr[17*nxt_idx +: 17] : '0;
         avmm.cfg_avmm_wdata    <= wr_n ? cfg_tbl_data[AVMM_WIDTH*nxt_idx +: AVMM_WIDTH] : '0;
         avmm.cfg_avmm_byte_en  <= wr_n ? '1 : '0;
         ns_adapter_rstn        <= rstn_n ? ACT_MASK : '0;
         ms_rx_dcc_dll_lock_req <= lock_n ? ACT_MASK : '0;
         ms_tx_dcc_dll_lock_req <= lock_n ? ACT_MASK : '0;
         ns_mac_rdy             <= lock_n ? ACT_MASK : '0;
         link_up                <= (nxt_state == S_LINK_UP);
         link_fail              <= (nxt_state == S_FAIL);
      end
   end

   assign retry_cnt = retry_q;
   assign seq_state = state_q;

endmodule

// File: tb/tb_aib_link_bringup_seq.sv
// Bench for aib_link_bringup_seq: directed bring-up scenarios with literal
// expectations, then randomized start/waitreq/status traffic, all checked
// every cycle against a phase/countdown model of the sequencer's rules.
module tb_aib_link_bringup_seq;
   localparam int NCH  = 24;
   localparam int ACT  = 2;
   localparam int NCFG = 3;
   localparam int RDLY = 8;
   localparam int STAB = 16;
   localparam int TOUT = 100;
   localparam int BOFF = 10;
   localparam int MAXR = 3;
   localparam logic [NCH-1:0] AMASK = 24'h000003;

   logic clk = 1'b0;
   logic rst, start;
   logic [NCFG*17-1:0] tbl_addr;
   logic [NCFG*32-1:0] tbl_data;
   logic [NCH-1:0] rstn, rx_lock, tx_lock, mac_rdy, fs, al;
   logic link_up, link_fail;
   logic [3:0] retry_cnt, seq_state;

   logic [16:0] ta [NCFG];
   logic [31:0] td [NCFG];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   aib_link_bringup_seq_if #(.AVMM_WIDTH(32), .BYTE_WIDTH(4)) bus ();

   aib_link_bringup_seq #(
      .NBR_CHNLS(NCH), .ACTIVE_CHNLS(ACT), .AVMM_WIDTH(32), .BYTE_WIDTH(4),
      .NUM_CFG(NCFG), .RST_DLY(RDLY), .STABLE_CYC(STAB), .TIMEOUT(TOUT),
      .BACKOFF_CYC(BOFF), .MAX_RETRY(MAXR)
   ) dut (
      .i_cfg_avmm_clk(clk), .i_cfg_avmm_rst(rst), .start(start),
      .cfg_tbl_addr(tbl_addr), .cfg_tbl_data(tbl_data), .avmm(bus.master),
      .ns_adapter_rstn(rstn), .ms_rx_dcc_dll_lock_req(rx_lock),
      .ms_tx_dcc_dll_lock_req(tx_lock), .ns_mac_rdy(mac_rdy),
      .fs_mac_rdy(fs), .m_rx_align_done(al),
      .link_up(link_up), .link_fail(link_fail),
      .retry_cnt(retry_cnt), .seq_state(seq_state)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase numbers are the externally visible seq_state codes.
   localparam int P_IDLE = 0, P_CFG = 1, P_RST = 2, P_LOCK = 3,
                  P_WAIT = 4, P_UP = 5, P_BACK = 6, P_FAIL = 7;
   int ph = P_IDLE, ent = 0, rst_left = 0, waited = 0, run = 0, back_left = 0, retries = 0;

   task automatic go_backoff();
      retries++;
      ph = P_BACK;
      back_left = BOFF;
   endtask

   task automatic model_step(input logic r, input logic s, input logic w, input logic k);
      if (r) begin
         ph = P_IDLE; ent = 0; retries = 0;
      end else if (ph != P_IDLE && ph != P_CFG && !s) begin
         ph = P_IDLE;
      end else begin
         case (ph)
            P_IDLE: if (s) begin ph = P_CFG; ent = 0; end
            P_CFG: if (!w) begin
               if (!s) ph = P_IDLE;
               else if (ent == NCFG-1) begin ph = P_RST; rst_left = RDLY; end
               else ent++;
            end
            P_RST: begin
               rst_left--;
               if (rst_left == 0) ph = P_LOCK;
            end
            P_LOCK: begin ph = P_WAIT; waited = 0; run = 0; end
            P_WAIT: begin
               waited++;
               run = k ? run + 1 : 0;
               if (run == STAB) ph = P_UP;
               else if (waited == TOUT) go_backoff();
            end
            P_UP: if (!k) go_backoff();
            P_BACK: begin
               if (retries > MAXR) ph = P_FAIL;
               else begin
                  back_left--;
                  if (back_left == 0) begin ph = P_RST; rst_left = RDLY; end
               end
            end
            default: ;
         endcase
      end
      if (ph == P_IDLE) retries = 0;
   endtask

   initial begin
      logic r, s, w, k;
      logic [NCH-1:0] ech;
      logic [NCH-1:0] elk;
      forever begin
         @(posedge clk);
         r = rst; s = start; w = bus.cfg_avmm_waitreq; k = &(fs[ACT-1:0] & al[ACT-1:0]);
         model_step(r, s, w, k);
         @(negedge clk);
         ech = (ph >= P_RST && ph <= P_UP) ? AMASK : '0;
         elk = (ph >= P_LOCK && ph <= P_UP) ? AMASK : '0;
         chk("m_state",   64'(seq_state), 64'(ph));
         chk("m_write",   64'(bus.cfg_avmm_write), 64'(ph == P_CFG));
         chk("m_addr",    64'(bus.cfg_avmm_addr), 64'((ph == P_CFG) ? ta[ent] : 17'd0));
         chk("m_wdata",   64'(bus.cfg_avmm_wdata), 64'((ph == P_CFG) ? td[ent] : 32'd0));
         chk("m_byte_en", 64'(bus.cfg_avmm_byte_en), 64'((ph == P_CFG) ? 4'hF : 4'h0));
         chk("m_rstn",    64'(rstn), 64'(ech));
         chk("m_lock",    64'({rx_lock, tx_lock, mac_rdy}), 64'({elk, elk, elk}));
         chk("m_link_up", 64'(link_up), 64'(ph == P_UP));
         chk("m_fail",    64'(link_fail), 64'(ph == P_FAIL));
         chk("m_retry",   64'(retry_cnt), 64'(retries));
      end
   end

   // ---------------- stimulus + literal checks ----------------
   task automatic set_ok(input logic v);
      fs = {22'($urandom), {ACT{v}}};
      al = {22'($urandom), {ACT{v}}};
   endtask

   initial begin
      int wcnt, first_w, last_w, first_r, cnt, hold, lockc, off_left, okpct;
      bit found;
      ta[0] = 17'h00010; ta[1] = 17'h10204; ta[2] = 17'h0ABCD;
      td[0] = 32'hDEAD_0001; td[1] = 32'h1234_5678; td[2] = 32'hCAFE_F00D;
      for (int i = 0; i < NCFG; i++) begin
         tbl_addr[17*i +: 17] = ta[i];
         tbl_data[32*i +: 32] = td[i];
      end
      rst = 1'b1; start = 1'b0; bus.cfg_avmm_waitreq = 1'b0; set_ok(1'b0);
      repeat (3) @(negedge clk);
      chk("rst_state", 64'(seq_state), 64'd0);
      chk("rst_outs", 64'({bus.cfg_avmm_write, link_up, link_fail, retry_cnt}), 64'd0);
      chk("rst_chan", 64'(rstn | rx_lock | tx_lock | mac_rdy), 64'd0);
      rst = 1'b0;

      // Three back-to-back writes, then adapter reset release one cycle later.
      @(negedge clk); start = 1'b1;
      wcnt = 0; first_w = -1; last_w = -1; first_r = -1;
      for (int c = 0; c < 30 && first_r < 0; c++) begin
         @(negedge clk);
         if (bus.cfg_avmm_write) begin
            wcnt++; last_w = c;
            if (first_w < 0) first_w = c;
         end
         if (rstn[0] && first_r < 0) first_r = c;
      end
      chk("cfg_writes", 64'(wcnt), 64'd3);
      chk("cfg_consec", 64'(last_w - first_w), 64'd2);
      chk("rstn_after", 64'(first_r), 64'(last_w + 1));

      // Status good from now: link_up after exactly STAB cycles in WAIT_ALIGN.
      set_ok(1'b1);
      cnt = 0; found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (seq_state == 4'd4) cnt++;
         if (link_up) found = 1;
      end
      chk("link_up_seen", 64'(found), 64'd1);
      chk("stable_cycles", 64'(cnt), 64'd16);

      // One-cycle alignment drop on channel 0 -> BACKOFF, then relock.
      al[0] = 1'b0;
      @(negedge clk); al[0] = 1'b1;
      chk("drop_state", 64'(seq_state), 64'd6);
      chk("drop_retry", 64'(retry_cnt), 64'd1);
      chk("drop_link", 64'(link_up), 64'd0);
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (link_up) found = 1;
      end
      chk("relink", 64'(found), 64'd1);
      chk("relink_retry", 64'(retry_cnt), 64'd1);

      // Never aligned: four attempts, then sticky FAIL with channels off.
      start = 1'b0; @(negedge clk);
      chk("abort_idle", 64'({seq_state, retry_cnt}), 64'd0);
      set_ok(1'b0); start = 1'b1;
      lockc = 0; found = 0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clk);
         if (seq_state == 4'd3) lockc++;
         if (link_fail) found = 1;
      end
      chk("fail_seen", 64'(found), 64'd1);
      chk("attempts", 64'(lockc), 64'd4);
      chk("fail_retry", 64'(retry_cnt), 64'd4);
      chk("fail_chan", 64'(rstn | rx_lock | mac_rdy), 64'd0);
      repeat (5) @(negedge clk);
      chk("fail_sticky", 64'({link_fail, seq_state}), 64'({1'b1, 4'd7}));

      // waitreq held 5 cycles on entry 1: request frozen, then entry 2.
      start = 1'b0; @(negedge clk);
      start = 1'b1; found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (bus.cfg_avmm_write && bus.cfg_avmm_addr == ta[1]) found = 1;
      end
      chk("entry1_seen", 64'(found), 64'd1);
      bus.cfg_avmm_waitreq = 1'b1; hold = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.cfg_avmm_write && bus.cfg_avmm_addr == ta[1] && bus.cfg_avmm_wdata == td[1]) hold++;
      end
      chk("hold_cycles", 64'(hold), 64'd5);
      bus.cfg_avmm_waitreq = 1'b0;
      @(negedge clk);
      chk("entry2_addr", 64'({bus.cfg_avmm_write, bus.cfg_avmm_addr}), 64'({1'b1, ta[2]}));
      @(negedge clk);
      chk("after_cfg", 64'({bus.cfg_avmm_write, seq_state}), 64'({1'b0, 4'd2}));

      // Abort under waitreq: strobe stays until accepted, then IDLE.
      start = 1'b0; @(negedge clk);
      bus.cfg_avmm_waitreq = 1'b1; start = 1'b1;
      @(negedge clk); @(negedge clk);
      start = 1'b0; hold = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.cfg_avmm_write && seq_state == 4'd1 && bus.cfg_avmm_addr == ta[0]) hold++;
      end
      chk("abort_hold", 64'(hold), 64'd3);
      bus.cfg_avmm_waitreq = 1'b0;
      @(negedge clk);
      chk("abort_done", 64'({seq_state, bus.cfg_avmm_write, link_up, rstn}), 64'd0);

      // Randomized traffic, checked by the model only.
      off_left = 0; okpct = 99;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (i % 250 == 0) okpct = (($urandom % 3) == 0) ? 0 : ((($urandom % 2) == 0) ? 99 : 92);
         if (off_left > 0) begin start = 1'b0; off_left--; end
         else begin
            start = 1'b1;
            if ($urandom % 400 == 0) off_left = $urandom_range(1, 4);
         end
         bus.cfg_avmm_waitreq = ($urandom % 3 == 0);
         set_ok(($urandom % 100) < okpct);
         rst = (i >= 2500 && i < 2502);
      end
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
